axis_unpack: RTL



---
 rtl/axis_unpack_pkg.sv | 22 ++
 rtl/axis_unpack.sv | 104 ++++++++++
 2 files changed

// File: rtl/axis_unpack_pkg.sv
// Shared types and elaboration helpers for the axis_unpack width down-converter.
package axis_unpack_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  function automatic int ratio_f(input int dw_in, input int dw_out);
    return dw_in / dw_out;
  endfunction

  // Never narrower than one bit so a degenerate ratio still elaborates far enough to report.
  function automatic int cnt_w_f(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  function automatic bit params_ok_f(input int dw_in, input int dw_out);
    return (dw_out > 0) && ((dw_in % dw_out) == 0) && ((dw_in / dw_out) >= 2);
  endfunction

endpackage

// File: rtl/axis_unpack.sv
// AXI-Stream serializer: one DW_IN word in, RATIO DW_OUT beats out, tlast on the final beat.
// Define AXIS_UNPACK_MSB_FIRST_EN to emit the most significant slice first (default LSB-first).
module axis_unpack
  import axis_unpack_pkg::*;
#(
  parameter int DW_IN  = 32,
  parameter int DW_OUT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DW_IN-1:0]  s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic [DW_OUT-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready
);

  localparam int RATIO = ratio_f(DW_IN, DW_OUT);
  localparam int CNT_W = cnt_w_f(RATIO);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  if (!params_ok_f(DW_IN, DW_OUT)) begin : gen_param_check
    $error("axis_unpack: DW_IN must be a multiple of DW_OUT with at least two beats per word");
  end

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [DW_IN-1:0]               holdWord_q, holdWord_d;
  logic                           heldLast_q, heldLast_d;
  logic                           sAccept;
  logic                           mBeat;
  logic                           lastBeat;
  logic [RATIO-1:0][DW_OUT-1:0]   holdBeats;
  logic [CNT_W-1:0]               beatSel;

  // The final beat frees the hold register, so a new word may land in the same cycle.
  assign lastBeat = (cnt_q == LAST_CNT);
  assign s_tready = !reset && ((state_q == IDLE) || (lastBeat && m_tready));
  assign sAccept  = s_tvalid && s_tready;
  assign m_tvalid = (state_q == SHIFT);
  assign mBeat    = m_tvalid && m_tready;

  assign holdBeats = holdWord_q;
`ifdef AXIS_UNPACK_MSB_FIRST_EN
  assign beatSel = LAST_CNT - cnt_q;
`else
  assign beatSel = cnt_q;
`endif
  assign m_tdata = holdBeats[beatSel];
  assign m_tlast = heldLast_q && lastBeat;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    holdWord_d = holdWord_q;
    heldLast_d = heldLast_q;
    case (state_q)
      IDLE: begin
        if (sAccept) begin
          state_d    = SHIFT;
          cnt_d      = '0;
          holdWord_d = s_tdata;
          heldLast_d = s_tlast;
        end
      end
      SHIFT: begin
        if (mBeat) begin
          if (!lastBeat) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else if (sAccept) begin
            cnt_d      = '0;
            holdWord_d = s_tdata;
            heldLast_d = s_tlast;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      holdWord_q <= '0;
      heldLast_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      holdWord_q <= holdWord_d;
      heldLast_q <= heldLast_d;
    end
  end

endmodule
